// File: rtl/tm1638_xfer.sv
// tm1638_xfer: TM1638 frame engine, command byte plus 0..MAX_LEN write or read data bytes per STB-low frame
module tm1638_xfer #(
   parameter int CLK_DIV   = 4,
   parameter int MAX_LEN   = 16,
   parameter int LEN_W     = 5,
   parameter int READ_WAIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rw,
   input  logic [7:0]       cmd_byte,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [7:0]       wr_data,
   output logic             rd_valid,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             done,
   output logic             stb,
   output logic             sclk,
   output logic             dio_out,
   output logic             dio_oe,
   input  logic             dio_in
);
   typedef enum logic [3:0] {IDLE, SETUP, CMD, WFETCH, WBYTE, TURN, RBYTE, HOLD, STB_HIGH} state_t;
   localparam int CW = $clog2(((2 * CLK_DIV > READ_WAIT) ? 2 * CLK_DIV : READ_WAIT) + 1);
   localparam logic [CW-1:0] LOW_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HIGH_FIRST = CW'(CLK_DIV);
   localparam logic [CW-1:0] CELL_LAST = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   state_t st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_cnt, bit_n;
   logic [7:0] sh, sh_n;
   logic [LEN_W-1:0] rem, rem_n;
   logic rw, rw_n, sample, half_end, cell_end;
   logic in_cell_n, stb_n, sclk_n, oe_n, dout_n;
   assign half_end  = cnt == LOW_LAST;
   assign cell_end  = cnt == CELL_LAST;
   assign cmd_ready = st == IDLE;
   assign busy      = st != IDLE;
   assign wr_ready  = st == WFETCH && wr_valid;
   // next-state: phase counter, bit counter, shift register and remaining-byte count
   always_comb begin
      st_n = st;
      cnt_n = cnt + 1'b1;
      bit_n = bit_cnt;
      sh_n = sh;
      rem_n = rem;
      rw_n = rw;
      sample = 1'b0;
      unique case (st)
         IDLE: begin
            cnt_n = '0;
            if (cmd_valid) begin
               st_n = SETUP;
               sh_n = cmd_byte;
               rw_n = cmd_rw;
               rem_n = cmd_len > LEN_MAX ? LEN_MAX : cmd_len;
            end
         end
         SETUP: if (half_end) begin
            st_n = CMD;
            cnt_n = '0;
            bit_n = '0;
         end
         CMD, WBYTE, RBYTE: begin
            if (st == RBYTE && half_end) begin
               sh_n = {dio_in, sh[7:1]};
               sample = 1'b1;
            end
            if (cell_end) begin
               cnt_n = '0;
               bit_n = bit_cnt + 3'd1;
               if (st != RBYTE) sh_n = {1'b1, sh[7:1]};
               if (bit_cnt == 3'd7) begin
                  if (st == CMD) st_n = rem == '0 ? HOLD : rw ? WFETCH : TURN;
                  else begin
                     rem_n = rem - 1'b1;
                     st_n = rem == LEN_W'(1) ? HOLD : st == WBYTE ? WFETCH : RBYTE;
                  end
               end
            end
         end
         WFETCH: begin
            cnt_n = '0;
            if (wr_valid) begin
               st_n = WBYTE;
               sh_n = wr_data;
               bit_n = '0;
            end
         end
         TURN: if (cnt == WAIT_LAST) begin
            st_n = RBYTE;
            cnt_n = '0;
            bit_n = '0;
         end
         HOLD: if (half_end) begin
            st_n = STB_HIGH;
            cnt_n = '0;
         end
         STB_HIGH: if (half_end) begin
            st_n = IDLE;
            cnt_n = '0;
         end
         default: st_n = IDLE;
      endcase
   end
   // pin values decoded from the next state so the board pins come straight from flops
   always_comb begin
      in_cell_n = st_n inside {CMD, WBYTE, RBYTE};
      stb_n = st_n == IDLE || st_n == STB_HIGH;
      sclk_n = !in_cell_n || cnt_n >= HIGH_FIRST;
      oe_n = st_n inside {CMD, WFETCH, WBYTE};
      dout_n = (st_n == CMD || st_n == WBYTE) ? sh_n[0] : 1'b1;
   end
   // state, datapath and registered pin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         sh <= '0;
         rem <= '0;
         rw <= 1'b0;
         stb <= 1'b1;
         sclk <= 1'b1;
         dio_out <= 1'b1;
         dio_oe <= 1'b0;
         done <= 1'b0;
         rd_valid <= 1'b0;
         rd_data <= '0;
      end else begin
         st <= st_n;
         cnt <= cnt_n;
         bit_cnt <= bit_n;
         sh <= sh_n;
         rem <= rem_n;
         rw <= rw_n;
         stb <= stb_n;
         sclk <= sclk_n;
         dio_out <= dout_n;
         dio_oe <= oe_n;
         done <= st == HOLD && st_n == STB_HIGH;
         rd_valid <= sample && bit_cnt == 3'd7;
         if (sample && bit_cnt == 3'd7) rd_data <= sh_n;
      end
   end
endmodule
